// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable, mux select and the ALU operation code.
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [5:0]         opcode_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic               branch_ne_o,
  output logic [1:0]         pc_source_o,
  output logic               i_or_d_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               reg_write_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [2:0]         alu_operation_o,
  output logic               illegal_op_o,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [STATE_W-1:0] {
    RESET     = STATE_W'(0),
    FETCH     = STATE_W'(1),
    DECODE    = STATE_W'(2),
    MEM_ADDR  = STATE_W'(3),
    MEM_READ  = STATE_W'(4),
    MEM_WB    = STATE_W'(5),
    MEM_WRITE = STATE_W'(6),
    R_EXEC    = STATE_W'(7),
    R_WB      = STATE_W'(8),
    BRANCH    = STATE_W'(9),
    JUMP      = STATE_W'(10),
    IMM_EXEC  = STATE_W'(11),
    IMM_WB    = STATE_W'(12),
    ILLEGAL   = STATE_W'(13)
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_operation;
    logic       illegal_op;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   fetch_ready;

  // Control word for a given state; registered alongside the state so outputs come straight from flops.
  function automatic ctrl_t decode_ctrl(state_e s, logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      DECODE:    c.alu_src_b = 2'b11;
      MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEM_READ:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      MEM_WB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      MEM_WRITE: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      R_EXEC:    begin c.alu_src_a = 1'b1; c.alu_operation = 3'b010; end
      R_WB:      begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_operation = 3'b001;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.branch_ne     = (op == OP_BNE);
      end
      JUMP:      begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      IMM_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        case (op)
          OP_ANDI: c.alu_operation = 3'b101;
          OP_ORI:  c.alu_operation = 3'b111;
          default: c.alu_operation = 3'b100;
        endcase
      end
      IMM_WB:    c.reg_write = 1'b1;
      ILLEGAL:   c.illegal_op = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:     state_d = FETCH;
      FETCH:     if (mem_ready_i) state_d = DECODE;
      DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW:             state_d = MEM_ADDR;
          OP_R:                     state_d = R_EXEC;
          OP_BEQ, OP_BNE:           state_d = BRANCH;
          OP_J:                     state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = IMM_EXEC;
          default:                  state_d = ILLEGAL;
        endcase
      end
      MEM_ADDR:  state_d = (opcode_i == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (mem_ready_i) state_d = MEM_WB;
      MEM_WRITE: if (mem_ready_i) state_d = FETCH;
      R_EXEC:    state_d = R_WB;
      IMM_EXEC:  state_d = IMM_WB;
      default:   state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RESET;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d, opcode_i);
    end
  end

  // IR and PC only load on the cycle the instruction fetch actually completes.
  assign fetch_ready     = (state_q == FETCH) && mem_ready_i;
  assign ir_write_o      = fetch_ready;
  assign pc_write_o      = ctrl_q.pc_write | fetch_ready;
  assign pc_write_cond_o = ctrl_q.pc_write_cond;
  assign branch_ne_o     = ctrl_q.branch_ne;
  assign pc_source_o     = ctrl_q.pc_source;
  assign i_or_d_o        = ctrl_q.i_or_d;
  assign mem_read_o      = ctrl_q.mem_read;
  assign mem_write_o     = ctrl_q.mem_write;
  assign reg_dst_o       = ctrl_q.reg_dst;
  assign mem_to_reg_o    = ctrl_q.mem_to_reg;
  assign reg_write_o     = ctrl_q.reg_write;
  assign alu_src_a_o     = ctrl_q.alu_src_a;
  assign alu_src_b_o     = ctrl_q.alu_src_b;
  assign alu_operation_o = ctrl_q.alu_operation;
  assign illegal_op_o    = ctrl_q.illegal_op;
  assign state_o         = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: each driven cycle pushes the expected state and
// control word, which is popped and compared mid-cycle.
module tb_multicycle_control_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic [3:0]  st;
    logic [18:0] ctrl;
  } exp_t;

  logic        clk, rst_n, mem_ready;
  logic [5:0]  opcode;
  logic        pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0]  pc_source, alu_src_b;
  logic [2:0]  alu_operation;
  logic [3:0]  state;
  logic [18:0] dutVec;
  exp_t        expQ[$];
  int          checks = 0;
  int          failures = 0;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .branch_ne_o(branch_ne),
    .pc_source_o(pc_source), .i_or_d_o(i_or_d), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .ir_write_o(ir_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_operation_o(alu_operation),
    .illegal_op_o(illegal_op), .state_o(state)
  );

  assign dutVec = {pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read, mem_write,
                   ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_operation,
                   illegal_op};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference control word for a state, written from the state table.
  function automatic logic [18:0] expCtrl(int st, logic [5:0] op, logic rdy);
    logic pcw, pcwc, bne, iord, mr, mw, irw, rd, m2r, rw, asa, ill;
    logic [1:0] pcs, asb;
    logic [2:0] aop;
    {pcw, pcwc, bne, iord, mr, mw, irw, rd, m2r, rw, asa, ill} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 3'b000;
    case (st)
      1:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      2:  asb = 2'b11;
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mr = 1; iord = 1; end
      5:  begin m2r = 1; rw = 1; end
      6:  begin mw = 1; iord = 1; end
      7:  begin asa = 1; aop = 3'b010; end
      8:  begin rd = 1; rw = 1; end
      9:  begin asa = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; bne = (op == OP_BNE); end
      10: begin pcw = 1; pcs = 2'b10; end
      11: begin
        asa = 1; asb = 2'b10;
        aop = (op == OP_ANDI) ? 3'b101 : (op == OP_ORI) ? 3'b111 : 3'b100;
      end
      12: rw = 1;
      13: ill = 1;
      default: ;
    endcase
    return {pcw, pcwc, bne, pcs, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, ill};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpected(input int st, input logic [5:0] op, input logic rdy);
    exp_t e;
    e.st   = 4'(st);
    e.ctrl = expCtrl(st, op, rdy);
    expQ.push_back(e);
  endtask

  task automatic sampleOutputs(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'(expQ.size()), 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, "_state"}, 32'(state), 32'(e.st));
      checkOutput({tag, "_ctrl"}, 32'(dutVec), 32'(e.ctrl));
    end
  endtask

  // Called at a falling edge: drive inputs, record expectation, check mid-cycle, advance.
  task automatic applyStimulus(input int st, input logic [5:0] op, input logic rdy, input string tag);
    opcode    = op;
    mem_ready = rdy;
    pushExpected(st, op, rdy);
    #2;
    sampleOutputs(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = OP_R;
    mem_ready = 1'b1;
    @(negedge clk);
    applyStimulus(0, OP_R, 1, "reset");
    rst_n = 1'b1;
    applyStimulus(0, OP_R, 1, "reset_release");

    applyStimulus(1, OP_R, 1, "r_fetch");
    applyStimulus(2, OP_R, 1, "r_decode");
    applyStimulus(7, OP_R, 1, "r_exec");
    applyStimulus(8, OP_R, 1, "r_wb");

    applyStimulus(1, OP_LW, 1, "lw_fetch");
    applyStimulus(2, OP_LW, 1, "lw_decode");
    applyStimulus(3, OP_LW, 1, "lw_addr");
    for (int i = 0; i < 2; i++) applyStimulus(4, OP_LW, 0, "lw_read_stall");
    applyStimulus(4, OP_LW, 1, "lw_read");
    applyStimulus(5, OP_LW, 1, "lw_wb");

    for (int i = 0; i < 3; i++) applyStimulus(1, OP_SW, 0, "fetch_stall");
    applyStimulus(1, OP_SW, 1, "sw_fetch");
    applyStimulus(2, OP_SW, 1, "sw_decode");
    applyStimulus(3, OP_SW, 1, "sw_addr");
    applyStimulus(6, OP_SW, 1, "sw_write");

    applyStimulus(1, OP_BEQ, 1, "beq_fetch");
    applyStimulus(2, OP_BEQ, 1, "beq_decode");
    applyStimulus(9, OP_BEQ, 1, "beq_branch");
    applyStimulus(1, OP_BNE, 1, "bne_fetch");
    applyStimulus(2, OP_BNE, 1, "bne_decode");
    applyStimulus(9, OP_BNE, 1, "bne_branch");
    applyStimulus(1, OP_J, 1, "j_fetch");
    applyStimulus(2, OP_J, 1, "j_decode");
    applyStimulus(10, OP_J, 1, "j_jump");

    applyStimulus(1, OP_ANDI, 1, "andi_fetch");
    applyStimulus(2, OP_ANDI, 1, "andi_decode");
    applyStimulus(11, OP_ANDI, 1, "andi_exec");
    applyStimulus(12, OP_ANDI, 1, "andi_wb");
    applyStimulus(1, OP_ORI, 1, "ori_fetch");
    applyStimulus(2, OP_ORI, 1, "ori_decode");
    applyStimulus(11, OP_ORI, 1, "ori_exec");
    applyStimulus(12, OP_ORI, 1, "ori_wb");
    applyStimulus(1, OP_ADDI, 1, "addi_fetch");
    applyStimulus(2, OP_ADDI, 1, "addi_decode");
    applyStimulus(11, OP_ADDI, 1, "addi_exec");
    applyStimulus(12, OP_ADDI, 1, "addi_wb");

    applyStimulus(1, OP_BAD, 1, "ill_fetch");
    applyStimulus(2, OP_BAD, 1, "ill_decode");
    applyStimulus(13, OP_BAD, 1, "ill_pulse");

    applyStimulus(1, OP_SW, 1, "sw2_fetch");
    applyStimulus(2, OP_SW, 1, "sw2_decode");
    applyStimulus(3, OP_SW, 1, "sw2_addr");
    applyStimulus(6, OP_SW, 0, "sw2_write_stall");
    // Reset lands mid-cycle while the store is still stalled; strobes must drop without a clock edge.
    mem_ready = 1'b0;
    pushExpected(0, OP_SW, 0);
    #2;
    rst_n = 1'b0;
    #1;
    sampleOutputs("async_reset");
    @(negedge clk);
    applyStimulus(0, OP_SW, 1, "held_reset");
    rst_n = 1'b1;
    applyStimulus(0, OP_R, 1, "reset_release2");
    applyStimulus(1, OP_R, 1, "refetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore-style main control state machine for the multi-cycle MIPS datapath.
- Decodes the IR opcode and produces every datapath enable and mux select.
- Drives the 3-bit alu_operation code consumed by the ALU control decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback, stalling on a memory ready handshake.

Parameters:
- STATE_W, 4, width of state register and debug state output (min 4).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; stable from DECODE until next FETCH
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if branch condition met
- branch_ne  out  1  condition polarity: 0 = load on ALU zero, 1 = load on not-zero
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- reg_write  out  1  register file write
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_operation  out  3  000 add, 001 sub, 010 R-type funct, 100 addi, 101 andi, 111 ori
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  STATE_W  current state (debug)

Behaviour:
- rst_n low: state = RESET (0) immediately; all outputs 0. RESET -> FETCH on first clock edge after release. Reset mid-instruction abandons it; no strobe survives reset assertion.
- All outputs not listed for a state are 0. Outputs decode from state only, except where gated by mem_ready as stated.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000, andi 001100, ori 001101.
- FETCH (1):
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_operation=000, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - Hold while mem_ready=0; -> DECODE when 1.
- DECODE (2): alu_src_a=0, alu_src_b=11, alu_operation=000. Next state by opcode:
  - lw/sw -> MEM_ADDR
  - R -> R_EXEC
  - beq/bne -> BRANCH
  - j -> JUMP
  - addi/andi/ori -> IMM_EXEC
  - else -> ILLEGAL
- MEM_ADDR (3): alu_src_a=1, alu_src_b=10, alu_operation=000; lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ (4): mem_read=1, i_or_d=1; hold until mem_ready, then -> MEM_WB.
- MEM_WB (5): reg_dst=0, mem_to_reg=1, reg_write=1; -> FETCH.
- MEM_WRITE (6): mem_write=1, i_or_d=1; hold until mem_ready, then -> FETCH.
- R_EXEC (7): alu_src_a=1, alu_src_b=00, alu_operation=010; -> R_WB.
- R_WB (8): reg_dst=1, mem_to_reg=0, reg_write=1; -> FETCH.
- BRANCH (9): alu_src_a=1, alu_src_b=00, alu_operation=001, pc_write_cond=1, pc_source=01, branch_ne=(opcode==bne); -> FETCH.
- JUMP (10): pc_write=1, pc_source=10; -> FETCH.
- IMM_EXEC (11): alu_src_a=1, alu_src_b=10, alu_operation = 100 addi / 101 andi / 111 ori; -> IMM_WB.
- IMM_WB (12): reg_dst=0, mem_to_reg=0, reg_write=1; -> FETCH.
- ILLEGAL (13): illegal_op=1 for exactly one cycle; -> FETCH. No register or memory write occurs.
- Unused encodings 14-15 -> FETCH next cycle, outputs 0.
- Latency with mem_ready tied 1, counted from first FETCH cycle:
  - lw 5, sw 4, R 4, addi/andi/ori 4, beq/bne 3, j 3, illegal 3 cycles.
  - Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- mem_read/mem_write never both 1. reg_write and mem_write never both 1.

Test Plan:
- Reset then R-type (opcode 000000), mem_ready=1 -> states 0,1,2,7,8,1; alu_operation 000,000,010 in FETCH/DECODE/R_EXEC; reg_write=1 and reg_dst=1 only in R_WB.
- lw (100011), mem_ready low 2 cycles in MEM_READ -> MEM_READ held 3 cycles with mem_read=1, i_or_d=1; then MEM_WB with mem_to_reg=1, reg_write=1; total 7 cycles.
- FETCH with mem_ready=0 for 3 cycles -> ir_write=pc_write=0 while stalled, both 1 on the ready cycle only; state then 2.
- beq (000100) then bne (000101) -> BRANCH with alu_operation=001, pc_write_cond=1, branch_ne 0 then 1; j (000010) -> pc_write=1, pc_source=10.
- andi (001100), ori (001101), addi (001000) -> IMM_EXEC alu_operation 101, 111, 100 respectively; IMM_WB reg_dst=0, reg_write=1.
- opcode 111111 -> illegal_op single-cycle pulse in state 13, then FETCH. rst_n pulled low during MEM_WRITE -> mem_write drops to 0 asynchronously and state=0.
